// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the uart16 transmit controller blocks.
package uart_ctrl_pkg;

  localparam int UART_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_e;

  // Bits needed to index v items; 1 is the floor so single-bit fields stay legal.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit after last_owner, wrapping.
module rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               any
);

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!any && req[j] && (j == (int'(last_owner) + off) % NUM_REQ)) begin
          any      = 1'b1;
          pick[j]  = 1'b1;
          pick_idx = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart16_tx_arbiter.sv
// Shares one uart16 transmitter among NUM_REQ requesters: grant, start, wait for
// the transmit_done rising edge (or a bounded timeout), then report to the owner.
module uart16_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = UART_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int IDX_W          = clog2(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          done_valid,
  output logic                          timeout,
  output logic [IDX_W-1:0]              done_id,
  output logic [DATA_WIDTH-1:0]         uart_datain,
  output logic                          uart_start_tx,
  input  logic                          uart_transmit_done,
  output state_e                        dbg_state
);

  localparam int CNT_W = clog2(TIMEOUT_CYCLES);

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_owner_q, last_owner_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   done_valid_q, done_valid_d;
  logic                   timeout_q, timeout_d;
  logic [IDX_W-1:0]       done_id_q, done_id_d;

  logic [NUM_REQ-1:0]     pick;
  logic [IDX_W-1:0]       pick_idx;
  logic                   any;
  logic                   rise;
  logic                   term;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req        (req),
    .last_owner (last_owner_q),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .any        (any)
  );

  // done_q tracks transmit_done every cycle, so a level already high at START
  // is seen as stale on the first WAIT cycle rather than as a completion.
  assign rise = (state_q == WAIT) && uart_transmit_done && !done_q;
  assign term = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      data_q       <= '0;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      done_q       <= 1'b0;
      cnt_q        <= '0;
      done_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      done_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      data_q       <= data_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
      done_valid_q <= done_valid_d;
      timeout_q    <= timeout_d;
      done_id_q    <= done_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (rise || term) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d      = '0;
    data_d       = data_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    done_d       = uart_transmit_done;
    cnt_d        = cnt_q;
    done_valid_d = 1'b0;
    timeout_d    = 1'b0;
    done_id_d    = done_id_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          grant_d = pick;
          owner_d = pick_idx;
          for (int j = 0; j < NUM_REQ; j++) begin
            if (pick[j]) data_d = req_data[j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      START: cnt_d = '0;
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Completion takes priority over a timeout landing on the same cycle.
        if (rise) begin
          done_valid_d = 1'b1;
          done_id_d    = owner_q;
          last_owner_d = owner_q;
        end else if (term) begin
          timeout_d    = 1'b1;
          done_id_d    = owner_q;
          last_owner_d = owner_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy          = (state_q == START) || (state_q == WAIT);
    uart_start_tx = (state_q == START);
  end

  assign grant       = grant_q;
  assign uart_datain = data_q;
  assign done_valid  = done_valid_q;
  assign timeout     = timeout_q;
  assign done_id     = done_id_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart16_tx_arbiter.sv
// Directed bench for uart16_tx_arbiter (4 requesters, 16-bit words, timeout of 8).
module tb_uart16_tx_arbiter;
  import uart_ctrl_pkg::*;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int TO = 8;

  logic             clock;
  logic             reset;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    grant;
  logic             busy;
  logic             done_valid;
  logic             timeout;
  logic [1:0]       done_id;
  logic [DW-1:0]    uart_datain;
  logic             uart_start_tx;
  logic             uart_transmit_done;
  state_e           dbg_state;

  int checks;
  int failures;

  uart16_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clock              (clock),
    .reset              (reset),
    .req                (req),
    .req_data           (req_data),
    .grant              (grant),
    .busy               (busy),
    .done_valid         (done_valid),
    .timeout            (timeout),
    .done_id            (done_id),
    .uart_datain        (uart_datain),
    .uart_start_tx      (uart_start_tx),
    .uart_transmit_done (uart_transmit_done),
    .dbg_state          (dbg_state)
  );

  // clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done_valid"}, 32'(done_valid), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_done_id"}, 32'(done_id), 32'd0);
    chk({tag, "_datain"}, 32'(uart_datain), 32'd0);
    chk({tag, "_start_tx"}, 32'(uart_start_tx), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  logic [DW-1:0] words [NR];
  int exp_owner;

  initial begin
    checks   = 0;
    failures = 0;
    words[0] = 16'hA000;
    words[1] = 16'hB001;
    words[2] = 16'hC002;
    words[3] = 16'hD003;

    reset = 1'b0;
    req = '0;
    req_data = '0;
    uart_transmit_done = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b1;
    tick();

    // Single request from requester 2
    req_data[2*DW +: DW] = 16'hFFAA;
    req = 4'b0100;
    tick();
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_datain", 32'(uart_datain), 32'hFFAA);
    chk("single_start", 32'(uart_start_tx), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    req = '0;
    tick();
    chk("single_grant_clr", 32'(grant), 32'd0);
    chk("single_start_clr", 32'(uart_start_tx), 32'd0);
    chk("single_state_wait", 32'(dbg_state), 32'(WAIT));
    tick();
    uart_transmit_done = 1'b1;
    tick();
    chk("single_done_valid", 32'(done_valid), 32'd1);
    chk("single_done_id", 32'(done_id), 32'd2);
    chk("single_timeout", 32'(timeout), 32'd0);
    chk("single_busy_clr", 32'(busy), 32'd0);
    uart_transmit_done = 1'b0;
    tick();
    chk("single_done_pulse", 32'(done_valid), 32'd0);
    chk("single_datain_hold", 32'(uart_datain), 32'hFFAA);

    // Reset in WAIT: owner after last_owner=2 scanning 3,0,1 is 1
    req = 4'b0010;
    tick();
    chk("rst_grant", 32'(grant), 32'h2);
    req = '0;
    tick();
    tick();
    chk("rst_in_wait", 32'(dbg_state), 32'(WAIT));
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("rst_async");
    uart_transmit_done = 1'b1;
    tick();
    chk("rst_hold_done", 32'(done_valid), 32'd0);
    chk("rst_hold_timeout", 32'(timeout), 32'd0);
    uart_transmit_done = 1'b0;
    tick();

    // All four requesting continuously; req0 wins first after reset
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = words[i];
    req = 4'b1111;
    reset = 1'b1;
    for (int f = 0; f < 5; f++) begin
      exp_owner = f % NR;
      tick();
      chk($sformatf("rr%0d_grant", f), 32'(grant), 32'(1 << exp_owner));
      chk($sformatf("rr%0d_datain", f), 32'(uart_datain), 32'(words[exp_owner]));
      chk($sformatf("rr%0d_start", f), 32'(uart_start_tx), 32'd1);
      tick();
      chk($sformatf("rr%0d_start_once", f), 32'(uart_start_tx), 32'd0);
      chk($sformatf("rr%0d_datain_wait", f), 32'(uart_datain), 32'(words[exp_owner]));
      tick();
      uart_transmit_done = 1'b1;
      tick();
      chk($sformatf("rr%0d_done_valid", f), 32'(done_valid), 32'd1);
      chk($sformatf("rr%0d_done_id", f), 32'(done_id), 32'(exp_owner));
      uart_transmit_done = 1'b0;
    end
    req = '0;
    tick();
    chk("rr_idle", 32'(dbg_state), 32'(IDLE));

    // Stale level: transmit_done already high through START (owner 1 after 0)
    uart_transmit_done = 1'b1;
    req = 4'b0010;
    tick();
    chk("stale_grant", 32'(grant), 32'h2);
    req = '0;
    tick();
    tick();
    chk("stale_no_done", 32'(done_valid), 32'd0);
    chk("stale_busy", 32'(busy), 32'd1);
    uart_transmit_done = 1'b0;
    tick();
    chk("stale_no_done2", 32'(done_valid), 32'd0);
    uart_transmit_done = 1'b1;
    tick();
    chk("stale_done_valid", 32'(done_valid), 32'd1);
    chk("stale_done_id", 32'(done_id), 32'd1);
    uart_transmit_done = 1'b0;
    tick();

    // Timeout: last_owner=1, req 0 and 3 -> scan 2,3 picks 3
    req = 4'b1001;
    tick();
    chk("to_grant", 32'(grant), 32'h8);
    req = 4'b0001;
    tick();
    for (int c = 1; c < TO; c++) begin
      tick();
      chk($sformatf("to_wait%0d", c), 32'(timeout), 32'd0);
      chk($sformatf("to_busy%0d", c), 32'(busy), 32'd1);
    end
    tick();
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_done_id", 32'(done_id), 32'd3);
    chk("to_no_done", 32'(done_valid), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);
    tick();
    chk("to_next_grant", 32'(grant), 32'h1);
    chk("to_pulse_clr", 32'(timeout), 32'd0);
    req = '0;

    // Done edge on the timeout terminal cycle: completion wins
    tick();
    for (int c = 1; c < TO; c++) tick();
    chk("sim_still_wait", 32'(dbg_state), 32'(WAIT));
    uart_transmit_done = 1'b1;
    tick();
    chk("sim_done_valid", 32'(done_valid), 32'd1);
    chk("sim_no_timeout", 32'(timeout), 32'd0);
    chk("sim_done_id", 32'(done_id), 32'd0);
    uart_transmit_done = 1'b0;
    tick();
    chk("sim_late_timeout", 32'(timeout), 32'd0);
    chk("sim_idle", 32'(dbg_state), 32'(IDLE));

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
